// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared defaults and clog2 helper for the I2C transmit path
package i2c_pkg;

  localparam int I2C_FIFO_DEPTH = 16;
  localparam int I2C_FIFO_WIDTH = 8;

  // Smallest n with 2**n >= value; used for pointer and level widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/i2c_tx_fifo.sv
// rtl/i2c_tx_fifo.sv - first-word-fall-through transmit FIFO for an I2C master; macro I2C_TX_FIFO_LEVEL_EN adds the Level port
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = I2C_FIFO_DEPTH,
  parameter int WIDTH = I2C_FIFO_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Wr_En,
  input  logic [WIDTH-1:0]      Wr_Data,
  input  logic                  Flush,
  input  logic                  Buff_Next,
  output logic [WIDTH-1:0]      Data_Tx,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Overflow,
`ifdef I2C_TX_FIFO_LEVEL_EN
  output logic                  Underflow,
  output logic [clog2(DEPTH):0] Level
`else
  output logic                  Underflow
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic        bn_q;
  logic        armed_q, armed_d;

  logic        empty;
  logic        full;
  logic        pop_edge;
  logic        pop_ok;
  logic        push_ok;

  // Status decode, Buff_Next edge detection and pointer/flag next state.
  // armed_q keeps a Buff_Next held high through reset from counting as a
  // pop until it has been seen low at least once afterwards.
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_edge    = Buff_Next && !bn_q && armed_q;
    pop_ok      = pop_edge && !empty;
    push_ok     = Wr_En && (!full || pop_ok);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    armed_d     = armed_q || !Buff_Next;

    if (Flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (Wr_En && full && !pop_ok) begin
        overflow_d = 1'b1;
      end
      if (pop_edge && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      bn_q        <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      bn_q        <= Buff_Next;
      armed_q     <= armed_d;
    end
  end

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge Clk) begin
    if (Rst_n && !Flush && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= Wr_Data;
    end
  end

  assign Data_Tx   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign Full      = full;
  assign Empty     = empty;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;

`ifdef I2C_TX_FIFO_LEVEL_EN
  assign Level = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// tb/tb_i2c_tx_fifo.sv - scoreboard bench for i2c_tx_fifo
module tb_i2c_tx_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             Clk;
  logic             Rst_n;
  logic             Wr_En;
  logic [WIDTH-1:0] Wr_Data;
  logic             Flush;
  logic             Buff_Next;
  logic [WIDTH-1:0] Data_Tx;
  logic             Full;
  logic             Empty;
  logic             Overflow;
  logic             Underflow;
`ifdef I2C_TX_FIFO_LEVEL_EN
  logic [4:0]       Level;
`endif

  i2c_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Wr_En     (Wr_En),
    .Wr_Data   (Wr_Data),
    .Flush     (Flush),
    .Buff_Next (Buff_Next),
    .Data_Tx   (Data_Tx),
    .Full      (Full),
    .Empty     (Empty),
    .Overflow  (Overflow),
`ifdef I2C_TX_FIFO_LEVEL_EN
    .Underflow (Underflow),
    .Level     (Level)
`else
    .Underflow (Underflow)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] sb[$];
  logic             exp_ovf;
  logic             exp_unf;
  logic [WIDTH-1:0] last_pop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".data"},  Data_Tx,   (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
    chk({tag, ".empty"}, Empty,     sb.size() == 0);
    chk({tag, ".full"},  Full,      sb.size() == DEPTH);
    chk({tag, ".ovf"},   Overflow,  exp_ovf);
    chk({tag, ".unf"},   Underflow, exp_unf);
`ifdef I2C_TX_FIFO_LEVEL_EN
    chk({tag, ".level"}, Level,     sb.size());
`endif
  endtask

  // One cycle with optional push and pop edge, mirrored in the scoreboard.
  task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic pe);
    bit pop_ok;
    bit push_ok;
    pop_ok  = pe && (sb.size() != 0);
    push_ok = we && ((sb.size() < DEPTH) || pop_ok);
    if (we && (sb.size() == DEPTH) && !pop_ok) exp_ovf = 1'b1;
    if (pe && (sb.size() == 0)) exp_unf = 1'b1;
    Wr_En = we;
    Wr_Data = wd;
    Buff_Next = pe;
    tick();
    Wr_En = 1'b0;
    if (pop_ok) last_pop = sb.pop_front();
    if (push_ok) sb.push_back(wd);
    if (pe) begin
      Buff_Next = 1'b0;
      tick();
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    step(1'b1, v, 1'b0);
  endtask

  task automatic pop(input string tag);
    check_state(tag);
    step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Wr_En = 1'b0;
    Wr_Data = '0;
    Flush = 1'b0;
    Buff_Next = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    sb.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    last_pop = '0;
    do_reset();
    check_state("reset");

    // Basic FWFT ordering
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    chk("fwft.head", Data_Tx, 8'hA0);
    pop("p0");
    pop("p1");
    pop("p2");
    chk("drain.data", Data_Tx, 8'h00);
    chk("drain.empty", Empty, 1'b1);

    // Held Buff_Next pops only once
    push(8'h10);
    Buff_Next = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    Buff_Next = 1'b0;
    void'(sb.pop_front());
    tick();
    check_state("hold");

    // Overflow and in-order drain
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      push(8'(i));
      if (i == DEPTH - 1) chk("fill.full", Full, 1'b1);
    end
    chk("ovf.set", Overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop("drain16");
    chk("ovf.last", last_pop, 8'h0F);
    check_state("drained");

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i));
    step(1'b1, 8'h55, 1'b1);
    chk("fullpp.full", Full, 1'b1);
    chk("fullpp.ovf", Overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop("fullpp");
    chk("fullpp.last", last_pop, 8'h55);

    // Pop edge on empty with same-cycle push, then Flush
    do_reset();
    step(1'b1, 8'h77, 1'b1);
    chk("emptypp.unf", Underflow, 1'b1);
    chk("emptypp.data", Data_Tx, 8'h77);
    check_state("emptypp");
    Flush = 1'b1;
    Wr_En = 1'b1;
    Wr_Data = 8'h99;
    tick();
    Flush = 1'b0;
    Wr_En = 1'b0;
    sb.delete();
    exp_unf = 1'b0;
    exp_ovf = 1'b0;
    check_state("flush");

    // Reset mid-operation discards entries
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    sb.delete();
    check_state("midreset");

    // Buff_Next held high across reset release is not a pop
    tick();
    push(8'h31);
    Buff_Next = 1'b1;
    Rst_n = 1'b0;
    sb.delete();
    tick();
    Rst_n = 1'b1;
    tick();
    push(8'h33);
    tick();
    tick();
    check_state("heldrst");
    Buff_Next = 1'b0;
    tick();
    pop("heldrst.pop");
    check_state("heldrst.after");

    // Randomised traffic through pointer wrap
    do_reset();
    for (int i = 0; i < 150; i++) begin
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
      check_state("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
